// File: rtl/hoaaned_err_monitor.sv
// Error-distance statistics collector for the LPL=6/UPL=10 approximate adder.
// Optional squared-error accumulator enabled by defining HOAANED_MON_SQERR_EN.
module hoaaned_err_monitor #(
  parameter int N     = 16,
  parameter int CNT_W = 16,
  parameter int ACC_W = 40
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_samples,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     a,
  input  logic [N-1:0]     b,
  input  logic [N:0]       approx,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sample_count,
  output logic [CNT_W-1:0] err_count,
  output logic [N:0]       max_ed,
  output logic [ACC_W-1:0] sum_ed
`ifdef HOAANED_MON_SQERR_EN
  ,
  output logic [2*N+9:0]   sum_sq_ed
`endif
);

  // Sum adder is wide enough for either operand so a large ED on a narrow
  // accumulator still saturates instead of wrapping.
  localparam int SUM_W = ((ACC_W > N + 1) ? ACC_W : N + 1) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] target;
  logic             drain_cnt;
  logic             start_acc;
  logic             accept;
  logic             last_accept;

  logic [N:0]       exact;
  logic [N:0]       ed_comb;
  logic             s1_valid;
  logic [N:0]       s1_ed;
  logic             s1_nz;
  logic [SUM_W-1:0] sum_wide;
  logic             sum_sat;

  assign start_acc   = start && ((state == IDLE) || (state == DONE));
  assign accept      = in_valid && (state == RUN);
  assign last_accept = accept && ((sample_count + CNT_W'(1)) == target);

  assign in_ready = (state == RUN);
  assign busy     = (state == RUN) || (state == DRAIN);
  assign done     = (state == DONE);

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: if (start) state_next = (num_samples == '0) ? DRAIN : RUN;
      RUN:        if (last_accept) state_next = DRAIN;
      DRAIN:      if (drain_cnt) state_next = DONE;
      default:    state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      target       <= '0;
      drain_cnt    <= 1'b0;
      sample_count <= '0;
    end else begin
      state     <= state_next;
      drain_cnt <= (state == DRAIN);
      if (start_acc) begin
        target       <= num_samples;
        sample_count <= '0;
      end else if (accept) begin
        sample_count <= sample_count + CNT_W'(1);
      end
    end
  end

  // Stage 1: exact sum and absolute error distance.
  assign exact   = {1'b0, a} + {1'b0, b};
  assign ed_comb = (approx >= exact) ? (approx - exact) : (exact - approx);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_ed    <= '0;
      s1_nz    <= 1'b0;
    end else begin
      s1_valid <= accept && !start_acc;
      if (accept) begin
        s1_ed <= ed_comb;
        s1_nz <= (ed_comb != '0);
      end
    end
  end

  assign sum_wide = SUM_W'(sum_ed) + SUM_W'(s1_ed);
  assign sum_sat  = (sum_wide[SUM_W-1:ACC_W] != '0);

  // Stage 2: saturating accumulation of the stage-1 result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count <= '0;
      max_ed    <= '0;
      sum_ed    <= '0;
    end else if (start_acc) begin
      err_count <= '0;
      max_ed    <= '0;
      sum_ed    <= '0;
    end else if (s1_valid) begin
      sum_ed <= sum_sat ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
      if (s1_nz && (err_count != {CNT_W{1'b1}})) err_count <= err_count + CNT_W'(1);
      if (s1_ed > max_ed) max_ed <= s1_ed;
    end
  end

`ifdef HOAANED_MON_SQERR_EN
  logic [2*N+1:0] sq_comb;
  logic [2*N+1:0] s1_sq;
  logic [2*N+10:0] sq_wide;

  assign sq_comb = (2*N+2)'(ed_comb) * (2*N+2)'(ed_comb);
  assign sq_wide = {1'b0, sum_sq_ed} + (2*N+11)'(s1_sq);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_sq     <= '0;
      sum_sq_ed <= '0;
    end else begin
      if (accept) s1_sq <= sq_comb;
      if (start_acc) sum_sq_ed <= '0;
      else if (s1_valid) sum_sq_ed <= sq_wide[2*N+10] ? {(2*N+10){1'b1}} : sq_wide[2*N+9:0];
    end
  end
`endif

endmodule

// File: tb/tb_hoaaned_err_monitor.sv
// Randomised bench for hoaaned_err_monitor; a queue of accepted EDs is the reference.
// A second instance with an 8-bit accumulator exercises sum_ed saturation.
module tb_hoaaned_err_monitor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] num_samples = '0;
  logic        in_valid = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic [16:0] approx = '0;

  logic        in_ready, busy, done;
  logic [15:0] sample_count, err_count;
  logic [16:0] max_ed;
  logic [39:0] sum_ed;
  logic        in_ready8, busy8, done8;
  logic [15:0] sample_count8, err_count8;
  logic [16:0] max_ed8;
  logic [7:0]  sum_ed8;
`ifdef HOAANED_MON_SQERR_EN
  logic [41:0] sum_sq_ed, sum_sq_ed8;
`endif

  int checks = 0;
  int errors = 0;
  int ed_q[$];

  hoaaned_err_monitor dut (
    .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .approx(approx),
    .busy(busy), .done(done), .sample_count(sample_count), .err_count(err_count),
    .max_ed(max_ed), .sum_ed(sum_ed)
`ifdef HOAANED_MON_SQERR_EN
    , .sum_sq_ed(sum_sq_ed)
`endif
  );

  hoaaned_err_monitor #(.ACC_W(8)) dut_sat (
    .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
    .in_valid(in_valid), .in_ready(in_ready8), .a(a), .b(b), .approx(approx),
    .busy(busy8), .done(done8), .sample_count(sample_count8), .err_count(err_count8),
    .max_ed(max_ed8), .sum_ed(sum_ed8)
`ifdef HOAANED_MON_SQERR_EN
    , .sum_sq_ed(sum_sq_ed8)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reference statistics over the first m accepted samples.
  task automatic check_stats(input int acc, input int m);
    longint s = 0;
    longint sq = 0;
    int mx = 0;
    int nz = 0;
    for (int i = 0; i < m; i++) begin
      s += ed_q[i];
      sq += longint'(ed_q[i]) * longint'(ed_q[i]);
      if (ed_q[i] > mx) mx = ed_q[i];
      if (ed_q[i] != 0) nz++;
    end
    if (nz > 65535) nz = 65535;
    chk("sample_count", sample_count, acc);
    chk("err_count", err_count, nz);
    chk("max_ed", max_ed, mx);
    chk("sum_ed", sum_ed, s);
    chk("sat_sample_count", sample_count8, acc);
    chk("sat_err_count", err_count8, nz);
    chk("sat_sum_ed", sum_ed8, (s > 255) ? 255 : s);
`ifdef HOAANED_MON_SQERR_EN
    chk("sum_sq_ed", sum_sq_ed, sq);
`else
    if (sq < 0) chk("sq_overflow", sq, 0);
`endif
  endtask

  task automatic chk_flags(input string tag, input bit r, input bit bz, input bit dn);
    chk({tag, "_in_ready"}, in_ready, r);
    chk({tag, "_busy"}, busy, bz);
    chk({tag, "_done"}, done, dn);
  endtask

  // emode 0: directed table, 1: ED=2, 2: ED=1, 3: random
  task automatic gen(input int emode, input int idx, output logic [15:0] aa,
                     output logic [15:0] bb, output logic [16:0] ap);
    int ex, d;
    aa = 16'($urandom_range(0, 32767));
    bb = 16'($urandom_range(0, 32767));
    ex = int'(aa) + int'(bb);
    d = 0;
    case (emode)
      0: begin
        if (idx == 0) begin aa = 0; bb = 0; ex = 0; d = 1; end
        else if (idx == 1) begin aa = 5; bb = 3; ex = 8; d = 0; end
        else if (idx == 2) begin aa = 100; bb = 28; ex = 128; d = 3; end
        else d = $urandom_range(0, 5);
      end
      1: d = 2;
      2: d = 1;
      default: d = $urandom_range(0, 7);
    endcase
    if (d > ex || $urandom_range(0, 1) == 0) ap = 17'(ex + d);
    else ap = 17'(ex - d);
    if (emode == 3 && $urandom_range(0, 3) == 0) begin
      aa = 16'($urandom);
      bb = 16'($urandom);
      ap = 17'($urandom);
    end
  endtask

  // vmode 0: valid always, 1: alternate cycles, 2: random
  task automatic run_batch(input int n, input int vmode, input int emode, input bit poke_start);
    int acc = 0;
    int prev;
    int budget = 20 * n + 50;
    int ex, d;
    bit tog = 1'b1;
    logic [15:0] aa, bb;
    logic [16:0] ap;
    ed_q.delete();
    start = 1'b1;
    num_samples = 16'(n);
    in_valid = 1'b0;
    cyc();
    start = 1'b0;
    chk_flags("post_start", n > 0, 1'b1, 1'b0);
    check_stats(0, 0);
    while (acc < n && budget > 0) begin
      gen(emode, acc, aa, bb, ap);
      a = aa; b = bb; approx = ap;
      case (vmode)
        0: in_valid = 1'b1;
        1: begin in_valid = tog; tog = ~tog; end
        default: in_valid = ($urandom_range(0, 9) < 6);
      endcase
      start = poke_start && ($urandom_range(0, 3) == 0);
      num_samples = 16'($urandom_range(0, 3));
      cyc();
      budget--;
      prev = acc;
      if (in_valid) begin
        ex = int'(aa) + int'(bb);
        d = int'(ap) - ex;
        ed_q.push_back(d < 0 ? -d : d);
        acc++;
      end
      check_stats(acc, prev);
      if (acc < n) chk("run_in_ready", in_ready, 1'b1);
    end
    if (acc < n) chk("batch_timeout", acc, n);
    start = 1'b0;
    chk_flags("drain0", 1'b0, 1'b1, 1'b0);
    in_valid = 1'b1;
    cyc();
    chk_flags("drain1", 1'b0, 1'b1, 1'b0);
    check_stats(acc, acc);
    cyc();
    chk_flags("done", 1'b0, 1'b0, 1'b1);
    check_stats(acc, acc);
    for (int i = 0; i < 2; i++) begin
      in_valid = $urandom_range(0, 1);
      cyc();
      chk_flags("hold", 1'b0, 1'b0, 1'b1);
      check_stats(acc, acc);
    end
    in_valid = 1'b0;
    $display("batch n=%0d vmode=%0d emode=%0d: count=%0d err=%0d max=%0d sum=%0d",
             n, vmode, emode, sample_count, err_count, max_ed, sum_ed);
  endtask

  initial begin
    cyc();
    chk_flags("reset", 1'b0, 1'b0, 1'b0);
    check_stats(0, 0);
    rst = 1'b0;
    cyc();

    run_batch(3, 0, 0, 1'b0);
    chk("t1_count", sample_count, 3);
    chk("t1_err", err_count, 2);
    chk("t1_max", max_ed, 3);
    chk("t1_sum", sum_ed, 4);
`ifdef HOAANED_MON_SQERR_EN
    chk("t1_sq", sum_sq_ed, 10);
`endif

    run_batch(4, 1, 1, 1'b0);
    chk("t2_sum", sum_ed, 8);
    chk("t2_count", sample_count, 4);

    run_batch(0, 0, 3, 1'b0);
    chk("t3_count", sample_count, 0);

    run_batch(300, 0, 2, 1'b0);
    chk("t4_sat_sum", sum_ed8, 255);
    chk("t4_sat_err", err_count8, 300);
    chk("t4_sat_max", max_ed8, 1);

    // Reset in the middle of a batch.
    start = 1'b1;
    num_samples = 16'd5;
    cyc();
    start = 1'b0;
    a = 16'd10; b = 16'd10; approx = 17'd23;
    in_valid = 1'b1;
    cyc();
    cyc();
    in_valid = 1'b0;
    chk("pre_rst_count", sample_count, 2);
    chk("pre_rst_sum", sum_ed, 3);
    #2 rst = 1'b1;
    #1;
    chk_flags("async_rst", 1'b0, 1'b0, 1'b0);
    chk("async_rst_count", sample_count, 0);
    chk("async_rst_err", err_count, 0);
    chk("async_rst_max", max_ed, 0);
    chk("async_rst_sum", sum_ed, 0);
    $display("mid-batch reset: count=%0d sum=%0d busy=%0d", sample_count, sum_ed, busy);
    cyc();
    rst = 1'b0;
    cyc();
    chk_flags("post_rst", 1'b0, 1'b0, 1'b0);

    run_batch(6, 2, 3, 1'b1);
    for (int t = 0; t < 6; t++)
      run_batch($urandom_range(1, 24), $urandom_range(0, 2), 3, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end

endmodule
